// File: rtl/plca_txop_claim_ctrl_pkg.sv
// Shared types and constants for the PLCA TXOP claim sequencer.
// Optional random pick build: define PLCA_RANDOM_PICK_EN.
package plca_claim_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEARN    = 3'd1,
    PICK     = 3'd2,
    CLAIM    = 3'd3,
    ASSIGNED = 3'd4,
    FAIL     = 3'd5
  } state_e;

  localparam int COORD_ID = 0;

  localparam int DEF_MAX_TXOP       = 32;
  localparam int DEF_LEARN_CYCLES   = 2;
  localparam int DEF_CONFIRM_CYCLES = 3;
  localparam int DEF_MAX_CLAIM      = 4;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Bits needed for a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int DEF_IDX_W = $clog2(DEF_MAX_TXOP);
  localparam int DEF_ATT_W = cnt_width(DEF_MAX_CLAIM);

endpackage

// File: rtl/plca_txop_claim_ctrl_if.sv
// Event and configuration bundle between the PLCA control diagram, the MAC-side
// node-ID logic and the claim sequencer.
interface plca_txop_claim_ctrl_if;
  logic       plca_en;
  logic       claim_req;
  logic       cycle_start;
  logic       txop_done;
  logic [7:0] txop_id;
  logic       txop_busy;
  logic       txop_collision;
  logic       claim_active;
  logic [7:0] claim_id;
  logic [7:0] node_id;
  logic       node_id_valid;
  logic       claim_fail;
  logic [3:0] attempt_cnt;

  modport master (
    output plca_en, claim_req, cycle_start, txop_done, txop_id, txop_busy, txop_collision,
    input  claim_active, claim_id, node_id, node_id_valid, claim_fail, attempt_cnt
  );

  modport slave (
    input  plca_en, claim_req, cycle_start, txop_done, txop_id, txop_busy, txop_collision,
    output claim_active, claim_id, node_id, node_id_valid, claim_fail, attempt_cnt
  );
endinterface

// File: rtl/plca_txop_claim_ctrl_table.sv
// TXOP occupancy bitmap with free-index search. The coordinator slot (ID 0) is
// implicitly occupied and not stored. PLCA_RANDOM_PICK_EN selects an LFSR-seeded scan.
module plca_txop_table
  import plca_claim_pkg::*;
#(
  parameter int MAX_TXOP = DEF_MAX_TXOP,
  localparam int IDX_W   = $clog2(MAX_TXOP)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set_en,
  input  logic [7:0]       set_id,
  input  logic             pick_go,
  output logic             pick_done,
  output logic             pick_found,
  output logic [IDX_W-1:0] pick_idx
);

  logic [MAX_TXOP-1:1] tbl_r;

  // Occupancy storage: cleared on LEARN entry, out-of-range IDs never decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_r <= {(MAX_TXOP-1){1'b0}};
    end else if (clear) begin
      tbl_r <= {(MAX_TXOP-1){1'b0}};
    end else if (set_en) begin
      for (int i = 1; i < MAX_TXOP; i++) begin
        if (set_id == 8'(i)) begin
          tbl_r[i] <= 1'b1;
        end
      end
    end else begin
      tbl_r <= tbl_r;
    end
  end

`ifdef PLCA_RANDOM_PICK_EN
  logic [15:0]      lfsr_r;
  logic             scan_busy_r;
  logic [IDX_W-1:0] scan_ptr_r;
  logic [IDX_W-1:0] scan_cnt_r;
  logic [IDX_W-1:0] start_s;
  logic [IDX_W-1:0] cur_s;
  logic [IDX_W-1:0] next_s;
  logic             found_s;
  logic             last_s;

  // Free-running LFSR, advanced every clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // One slot per clock, wrapping past the top and skipping the coordinator.
  always_comb begin
    start_s = IDX_W'(lfsr_r % 16'(MAX_TXOP - 1)) + IDX_W'(1);
    cur_s   = scan_busy_r ? scan_ptr_r : start_s;
    if (cur_s == IDX_W'(MAX_TXOP - 1)) begin
      next_s = IDX_W'(1);
    end else begin
      next_s = cur_s + IDX_W'(1);
    end
    found_s = !tbl_r[cur_s];
    last_s  = (scan_cnt_r == IDX_W'(MAX_TXOP - 2));
  end

  // Scan pointer: restarts whenever the controller is not waiting on a pick.
  always_ff @(posedge clk) begin
    if (reset || !pick_go || pick_done) begin
      scan_busy_r <= 1'b0;
      scan_ptr_r  <= {IDX_W{1'b0}};
      scan_cnt_r  <= {IDX_W{1'b0}};
    end else begin
      scan_busy_r <= 1'b1;
      scan_ptr_r  <= next_s;
      scan_cnt_r  <= scan_cnt_r + IDX_W'(1);
    end
  end

  assign pick_done  = pick_go && (found_s || last_s);
  assign pick_found = found_s;
  assign pick_idx   = cur_s;
`else
  logic [IDX_W-1:0] idx_s;
  logic             found_s;

  // Lowest clear slot above the coordinator; descending scan leaves the lowest.
  always_comb begin
    idx_s   = {IDX_W{1'b0}};
    found_s = 1'b0;
    for (int i = MAX_TXOP - 1; i >= 1; i--) begin
      if (!tbl_r[i]) begin
        idx_s   = IDX_W'(i);
        found_s = 1'b1;
      end else begin
        idx_s   = idx_s;
        found_s = found_s;
      end
    end
  end

  assign pick_done  = pick_go;
  assign pick_found = found_s;
  assign pick_idx   = idx_s;
`endif

endmodule

// File: rtl/plca_txop_claim_ctrl.sv
// PLCA dynamic node-ID claim sequencer: learn occupied TXOPs, pick a free one,
// claim and confirm it, with bounded retries. Random pick via PLCA_RANDOM_PICK_EN.
module plca_txop_claim_ctrl
  import plca_claim_pkg::*;
#(
  parameter int MAX_TXOP       = DEF_MAX_TXOP,
  parameter int LEARN_CYCLES   = DEF_LEARN_CYCLES,
  parameter int CONFIRM_CYCLES = DEF_CONFIRM_CYCLES,
  parameter int MAX_CLAIM      = DEF_MAX_CLAIM
) (
  input  logic                  clk,
  input  logic                  reset,
  plca_txop_claim_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(MAX_TXOP);
  localparam int CYC_W = cnt_width(LEARN_CYCLES);
  localparam int CNF_W = cnt_width(CONFIRM_CYCLES);
  localparam int ATT_W = cnt_width(MAX_CLAIM);

  state_e           state_r, state_s;
  logic [CYC_W-1:0] cyc_cnt_r, cyc_cnt_s;
  logic [CNF_W-1:0] conf_cnt_r, conf_cnt_s;
  logic [ATT_W-1:0] attempt_cnt_r, attempt_cnt_s;
  logic [ATT_W-1:0] att_inc_s;
  logic             att_lim_s;
  logic [7:0]       claim_id_r, claim_id_s;
  logic [7:0]       node_id_r, node_id_s;
  logic             claim_active_r;
  logic             node_id_valid_r;
  logic             claim_fail_r;
  logic             own_s;
  logic             learn_clr_s;
  logic             set_en_s;
  logic             pick_go_s;
  logic             pick_done_s;
  logic             pick_found_s;
  logic [IDX_W-1:0] pick_idx_s;

  plca_txop_table #(.MAX_TXOP(MAX_TXOP)) u_table (
    .clk        (clk),
    .reset      (reset),
    .clear      (learn_clr_s),
    .set_en     (set_en_s),
    .set_id     (bus.txop_id),
    .pick_go    (pick_go_s),
    .pick_done  (pick_done_s),
    .pick_found (pick_found_s),
    .pick_idx   (pick_idx_s)
  );

  // Next-state, counter and claim bookkeeping.
  always_comb begin
    state_s       = state_r;
    cyc_cnt_s     = cyc_cnt_r;
    conf_cnt_s    = conf_cnt_r;
    attempt_cnt_s = attempt_cnt_r;
    claim_id_s    = claim_id_r;
    node_id_s     = node_id_r;
    own_s         = bus.txop_done && (bus.txop_id == claim_id_r);
    if (attempt_cnt_r < ATT_W'(MAX_CLAIM)) begin
      att_inc_s = attempt_cnt_r + ATT_W'(1);
    end else begin
      att_inc_s = attempt_cnt_r;
    end
    att_lim_s = (att_inc_s == ATT_W'(MAX_CLAIM));

    case (state_r)
      IDLE: begin
        if (bus.claim_req) begin
          state_s = LEARN;
        end else begin
          state_s = IDLE;
        end
      end
      LEARN: begin
        if (bus.cycle_start && (cyc_cnt_r == CYC_W'(LEARN_CYCLES - 1))) begin
          state_s   = PICK;
          cyc_cnt_s = {CYC_W{1'b0}};
        end else if (bus.cycle_start) begin
          cyc_cnt_s = cyc_cnt_r + CYC_W'(1);
        end else begin
          cyc_cnt_s = cyc_cnt_r;
        end
      end
      PICK: begin
        if (pick_done_s && pick_found_s) begin
          claim_id_s = 8'(pick_idx_s);
          state_s    = CLAIM;
        end else if (pick_done_s) begin
          attempt_cnt_s = att_inc_s;
          state_s       = att_lim_s ? FAIL : LEARN;
        end else begin
          state_s = PICK;
        end
      end
      CLAIM: begin
        if (own_s && bus.txop_collision) begin
          conf_cnt_s    = {CNF_W{1'b0}};
          attempt_cnt_s = att_inc_s;
          state_s       = att_lim_s ? FAIL : LEARN;
        end else if (own_s && (conf_cnt_r == CNF_W'(CONFIRM_CYCLES - 1))) begin
          conf_cnt_s = {CNF_W{1'b0}};
          node_id_s  = claim_id_r;
          state_s    = ASSIGNED;
        end else if (own_s) begin
          conf_cnt_s = conf_cnt_r + CNF_W'(1);
        end else begin
          conf_cnt_s = conf_cnt_r;
        end
      end
      ASSIGNED: begin
        if (own_s && bus.txop_collision) begin
          attempt_cnt_s = {ATT_W{1'b0}};
          state_s       = LEARN;
        end else if (!bus.claim_req) begin
          state_s = IDLE;
        end else begin
          state_s = ASSIGNED;
        end
      end
      FAIL: begin
        if (!bus.claim_req) begin
          attempt_cnt_s = {ATT_W{1'b0}};
          state_s       = IDLE;
        end else begin
          state_s = FAIL;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Losing PLCA abandons everything except the last confirmed node ID.
    if (!bus.plca_en) begin
      state_s       = IDLE;
      cyc_cnt_s     = {CYC_W{1'b0}};
      conf_cnt_s    = {CNF_W{1'b0}};
      attempt_cnt_s = {ATT_W{1'b0}};
    end else begin
      state_s = state_s;
    end

    learn_clr_s = (state_s == LEARN) && (state_r != LEARN);
    if (learn_clr_s) begin
      cyc_cnt_s = {CYC_W{1'b0}};
    end else begin
      cyc_cnt_s = cyc_cnt_s;
    end
    set_en_s  = (state_r == LEARN) && bus.txop_done && bus.txop_busy;
    pick_go_s = (state_r == PICK);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      cyc_cnt_r       <= {CYC_W{1'b0}};
      conf_cnt_r      <= {CNF_W{1'b0}};
      attempt_cnt_r   <= {ATT_W{1'b0}};
      claim_id_r      <= 8'h00;
      node_id_r       <= 8'h00;
      claim_active_r  <= 1'b0;
      node_id_valid_r <= 1'b0;
      claim_fail_r    <= 1'b0;
    end else begin
      state_r         <= state_s;
      cyc_cnt_r       <= cyc_cnt_s;
      conf_cnt_r      <= conf_cnt_s;
      attempt_cnt_r   <= attempt_cnt_s;
      claim_id_r      <= claim_id_s;
      node_id_r       <= node_id_s;
      claim_active_r  <= (state_s == CLAIM);
      node_id_valid_r <= (state_s == ASSIGNED);
      claim_fail_r    <= (state_s == FAIL);
    end
  end

  assign bus.claim_active  = claim_active_r;
  assign bus.claim_id      = claim_id_r;
  assign bus.node_id       = node_id_r;
  assign bus.node_id_valid = node_id_valid_r;
  assign bus.claim_fail    = claim_fail_r;
  assign bus.attempt_cnt   = 4'(attempt_cnt_r);

endmodule

// File: tb/tb_plca_txop_claim_ctrl.sv
// Scoreboard bench for plca_txop_claim_ctrl: stimulus queues expected output
// events, a negedge monitor detects output transitions and checks them in order.
module tb_plca_txop_claim_ctrl;

  localparam int EV_DROP     = 1;  // claim_active fell; val = own TXOPs seen while high
  localparam int EV_UNASSIGN = 2;  // node_id_valid fell; val = node_id
  localparam int EV_ATT      = 3;  // attempt_cnt changed; val = new value
  localparam int EV_CLAIM    = 4;  // claim_active rose; val = claim_id
  localparam int EV_ASSIGN   = 5;  // node_id_valid rose; val = node_id
  localparam int EV_FAIL     = 6;  // claim_fail rose; val = attempt_cnt

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   own_cnt = 0;
  bit   mon_en = 1'b0;
  logic p_ca, p_nv, p_cf;
  logic [3:0] p_att;
  ev_t  exp_q[$];

  plca_txop_claim_ctrl_if bus();

  plca_txop_claim_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d, none queued", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL event: got kind=%0d val=%0d, expected kind=%0d val=%0d",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: every transition must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!bus.claim_active && p_ca) expect_ev(EV_DROP, own_cnt);
      if (!bus.node_id_valid && p_nv) expect_ev(EV_UNASSIGN, int'(bus.node_id));
      if (bus.attempt_cnt != p_att) expect_ev(EV_ATT, int'(bus.attempt_cnt));
      if (bus.claim_active && !p_ca) begin
        expect_ev(EV_CLAIM, int'(bus.claim_id));
        own_cnt = 0;
      end
      if (bus.node_id_valid && !p_nv) expect_ev(EV_ASSIGN, int'(bus.node_id));
      if (bus.claim_fail && !p_cf) expect_ev(EV_FAIL, int'(bus.attempt_cnt));
      if (bus.claim_active && bus.txop_done && bus.txop_id == bus.claim_id) own_cnt++;
      p_ca  = bus.claim_active;
      p_nv  = bus.node_id_valid;
      p_cf  = bus.claim_fail;
      p_att = bus.attempt_cnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic done_pulse(input int id, input logic busy, input logic coll);
    bus.txop_done      = 1'b1;
    bus.txop_id        = 8'(id);
    bus.txop_busy      = busy;
    bus.txop_collision = coll;
    tick();
    bus.txop_done      = 1'b0;
    bus.txop_busy      = 1'b0;
    bus.txop_collision = 1'b0;
  endtask

  task automatic own(input int id, input logic coll);
    done_pulse(id, 1'b1, coll);
    tick();
    tick();
  endtask

  // Two PLCA cycles of busy reports; cs_id (if >=0) ends alongside the final beacon.
  task automatic learn(input logic [31:0] mask, input int extra, input int cs_id);
    tick();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 32; i++) begin
        if (mask[i]) done_pulse(i, 1'b1, 1'b0);
      end
      if (extra >= 0) done_pulse(extra, 1'b1, 1'b0);
      bus.cycle_start = 1'b1;
      if (c == 1 && cs_id >= 0) begin
        bus.txop_done = 1'b1;
        bus.txop_id   = 8'(cs_id);
        bus.txop_busy = 1'b1;
      end
      tick();
      bus.cycle_start = 1'b0;
      bus.txop_done   = 1'b0;
      bus.txop_busy   = 1'b0;
    end
  endtask

  task automatic wait_claim();
    int n = 0;
    while (!bus.claim_active && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.claim_active) begin
      errors++;
      $display("FAIL wait_claim: claim_active=%0b after %0d clocks, expected 1", bus.claim_active, n);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_claim_active", int'(bus.claim_active), 0);
    chk("rst_claim_id", int'(bus.claim_id), 0);
    chk("rst_node_id", int'(bus.node_id), 0);
    chk("rst_node_id_valid", int'(bus.node_id_valid), 0);
    chk("rst_claim_fail", int'(bus.claim_fail), 0);
    chk("rst_attempt_cnt", int'(bus.attempt_cnt), 0);
  endtask

  initial begin
    logic [31:0] m;
    bus.plca_en = 1'b1;
    bus.claim_req = 1'b0;
    bus.cycle_start = 1'b0;
    bus.txop_done = 1'b0;
    bus.txop_id = 8'h00;
    bus.txop_busy = 1'b0;
    bus.txop_collision = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk_reset_vals();
    p_ca = 1'b0; p_nv = 1'b0; p_cf = 1'b0; p_att = 4'd0;
    mon_en = 1'b1;

    // Clean claim of ID 3 with 0..2 busy.
    bus.claim_req = 1'b1;
    push(EV_CLAIM, 3);
    learn(32'h0000_0007, -1, -1);
    wait_claim();
    push(EV_DROP, 3);
    push(EV_ASSIGN, 3);
    repeat (3) own(3, 1'b0);
    push(EV_UNASSIGN, 3);
    bus.claim_req = 1'b0;
    tick();
    tick();
    chk("node_id_hold", int'(bus.node_id), 3);
    chk("node_id_valid_idle", int'(bus.node_id_valid), 0);

    // One collision then a clean claim of ID 5, then a collision after assignment.
    bus.claim_req = 1'b1;
    push(EV_CLAIM, 3);
    learn(32'h0000_0007, -1, -1);
    wait_claim();
    push(EV_DROP, 1);
    push(EV_ATT, 1);
    own(3, 1'b1);
    push(EV_CLAIM, 5);
    learn(32'h0000_001F, -1, -1);
    wait_claim();
    push(EV_DROP, 3);
    push(EV_ASSIGN, 5);
    repeat (3) own(5, 1'b0);
    chk("attempt_after_retry", int'(bus.attempt_cnt), 1);
    push(EV_UNASSIGN, 5);
    push(EV_ATT, 0);
    own(5, 1'b1);
    bus.claim_req = 1'b0;
    bus.plca_en = 1'b0;
    tick();
    bus.plca_en = 1'b1;
    tick();

    // Collision on every attempt until FAIL.
    bus.claim_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      push(EV_CLAIM, 3);
      learn(32'h0000_0007, -1, -1);
      wait_claim();
      push(EV_DROP, 1);
      push(EV_ATT, k);
      if (k == 4) push(EV_FAIL, 4);
      own(3, 1'b1);
    end
    chk("fail_claim_fail", int'(bus.claim_fail), 1);
    chk("fail_attempt_cnt", int'(bus.attempt_cnt), 4);
    push(EV_ATT, 0);
    bus.claim_req = 1'b0;
    tick();
    tick();
    chk("fail_cleared", int'(bus.claim_fail), 0);

    // Every non-coordinator TXOP busy: PICK finds nothing each time.
    bus.claim_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      push(EV_ATT, k);
      if (k == 4) push(EV_FAIL, 4);
      learn(32'hFFFF_FFFF, -1, -1);
      repeat (40) tick();
    end
    push(EV_ATT, 0);
    bus.claim_req = 1'b0;
    tick();
    tick();

    // Only ID 17 free.
    m = 32'h0000_0001 << 17;
    m = ~m;
    push(EV_CLAIM, 17);
    push(EV_DROP, 3);
    push(EV_ASSIGN, 17);
    bus.claim_req = 1'b1;
    learn(m, -1, -1);
    wait_claim();
    repeat (3) own(17, 1'b0);
    push(EV_UNASSIGN, 17);
    bus.claim_req = 1'b0;
    tick();
    tick();

    // Out-of-range ID ignored, report coincident with the last beacon kept,
    // foreign collision ignored, then PLCA dropped mid-claim.
    bus.claim_req = 1'b1;
    push(EV_CLAIM, 8);
    learn(32'h0000_007F, 40, 7);
    wait_claim();
    done_pulse(9, 1'b1, 1'b1);
    push(EV_DROP, 0);
    bus.plca_en = 1'b0;
    tick();
    chk("plca_off_claim_active", int'(bus.claim_active), 0);
    chk("plca_off_attempt", int'(bus.attempt_cnt), 0);
    bus.plca_en = 1'b1;
    bus.claim_req = 1'b0;
    tick();

    // Reset mid-claim discards the partial confirm count.
    bus.claim_req = 1'b1;
    push(EV_CLAIM, 3);
    learn(32'h0000_0007, -1, -1);
    wait_claim();
    push(EV_DROP, 1);
    done_pulse(3, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals();
    push(EV_CLAIM, 3);
    push(EV_DROP, 3);
    push(EV_ASSIGN, 3);
    learn(32'h0000_0007, -1, -1);
    wait_claim();
    repeat (3) own(3, 1'b0);
    push(EV_UNASSIGN, 3);
    bus.claim_req = 1'b0;
    repeat (5) tick();

    chk("pending_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
